// File: rtl/csa_acc_pkg.sv
// rtl/csa_acc_pkg.sv - state type, 3:2 compressor and width legality check for the CSA accumulator
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } acc_state_t;

  // Full-adder cell applied per bit: {carry, sum}; carry is the majority of the inputs.
  function automatic logic [1:0] csa3(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // The accumulator must hold LANES operands plus the redundant S/C pair without losing magnitude.
  function automatic bit acc_width_ok(input int lanes, input int width, input int acc_width);
    return acc_width >= width + $clog2(lanes + 2);
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// rtl/csa_stream_accumulator_if.sv - operand input stream and packet result stream of the CSA accumulator
interface csa_stream_accumulator_if #(
  parameter int LANES     = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        out_sum;
  logic [15:0]                 out_beats;

  // Accumulator side: consumes operand beats, produces packet totals.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats
  );

endinterface

// File: rtl/csa_reduce_tree.sv
// rtl/csa_reduce_tree.sv - combinational Wallace-style reduction of ROWS rows to a sum/carry pair
module csa_reduce_tree
  import csa_acc_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int W    = 24
) (
  input  logic [ROWS-1:0][W-1:0] rows_in,
  output logic [W-1:0]           sum_row,
  output logic [W-1:0]           carry_row
);

  // Rows left after one layer: every full group of three becomes two, leftovers pass through.
  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int n0, input int layer);
    int n;
    n = n0;
    for (int i = 0; i < layer; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int num_layers(input int n0);
    int n;
    int k;
    n = n0;
    k = 0;
    while (n > 2) begin
      n = rows_after(n);
      k++;
    end
    return k;
  endfunction

  localparam int NLAYERS = num_layers(ROWS);

  for (genvar l = 0; l < NLAYERS; l++) begin : g_layer
    localparam int NIN  = rows_at(ROWS, l);
    localparam int NGRP = NIN / 3;
    localparam int NOUT = rows_after(NIN);

    logic [NIN-1:0][W-1:0]  layer_in;
    logic [NOUT-1:0][W-1:0] layer_out;

    if (l == 0) begin : g_first
      assign layer_in = rows_in;
    end else begin : g_chain
      assign layer_in = g_layer[l-1].layer_out;
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      logic [W-1:0] s_bits;
      logic [W-1:0] c_bits;

      // Compress three rows bit by bit; the carry row gains weight 2 via the shift below.
      always_comb begin
        s_bits = '0;
        c_bits = '0;
        for (int b = 0; b < W; b++) begin
          {c_bits[b], s_bits[b]} = csa3(layer_in[3*g][b], layer_in[3*g+1][b], layer_in[3*g+2][b]);
        end
      end

      assign layer_out[2*g]   = s_bits;
      assign layer_out[2*g+1] = {c_bits[W-2:0], 1'b0};
    end

    for (genvar r = 3 * NGRP; r < NIN; r++) begin : g_pass
      assign layer_out[2*NGRP + r - 3*NGRP] = layer_in[r];
    end
  end

  assign sum_row   = g_layer[NLAYERS-1].layer_out[0];
  assign carry_row = g_layer[NLAYERS-1].layer_out[1];

endmodule

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - carry-save packet accumulator; CSA_ACC_SIGNED_EN selects two's-complement operands
module csa_stream_accumulator
  import csa_acc_pkg::*;
#(
  parameter int LANES     = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  csa_stream_accumulator_if.slave   bus
);

  if (!acc_width_ok(LANES, WIDTH, ACC_WIDTH)) begin : g_bad_width
    $error("csa_stream_accumulator: ACC_WIDTH too small for LANES/WIDTH");
  end

  localparam int ROWS = LANES + 2;

  acc_state_t                      state;
  acc_state_t                      state_nxt;
  logic [ACC_WIDTH-1:0]            s_q;
  logic [ACC_WIDTH-1:0]            c_q;
  logic [15:0]                     cnt_q;
  logic                            in_ready_q;
  logic                            out_valid_q;
  logic [ACC_WIDTH-1:0]            out_sum_q;
  logic [15:0]                     out_beats_q;
  logic [ROWS-1:0][ACC_WIDTH-1:0]  tree_rows;
  logic [ACC_WIDTH-1:0]            tree_sum;
  logic [ACC_WIDTH-1:0]            tree_carry;
  logic                            accept;
  logic                            out_fire;

  assign accept   = bus.in_valid && in_ready_q && (state == ST_ACCUM);
  assign out_fire = out_valid_q && bus.out_ready && (state == ST_OUTPUT);

  // Feed the redundant pair back in alongside the extended operands of the current beat.
  always_comb begin
    tree_rows    = '0;
    tree_rows[0] = s_q;
    tree_rows[1] = c_q;
    for (int i = 0; i < LANES; i++) begin
`ifdef CSA_ACC_SIGNED_EN
      tree_rows[i+2] = ACC_WIDTH'($signed(bus.in_data[i]));
`else
      tree_rows[i+2] = ACC_WIDTH'(bus.in_data[i]);
`endif
    end
  end

  csa_reduce_tree #(
    .ROWS (ROWS),
    .W    (ACC_WIDTH)
  ) u_tree (
    .rows_in   (tree_rows),
    .sum_row   (tree_sum),
    .carry_row (tree_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCUM;
    else        state <= state_nxt;
  end

  // Packet sequencing: accumulate until the last beat, resolve once, hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM:   if (accept && bus.in_last) state_nxt = ST_RESOLVE;
      ST_RESOLVE: state_nxt = ST_OUTPUT;
      ST_OUTPUT:  if (out_fire) state_nxt = ST_ACCUM;
      default:    state_nxt = ST_ACCUM;
    endcase
  end

  // Datapath: CSA fold per beat, single carry-propagate add in RESOLVE, clear on result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      // Registered from the next state so in_ready never depends on in_valid combinationally.
      in_ready_q <= (state_nxt == ST_ACCUM);
      if (accept) begin
        s_q <= tree_sum;
        c_q <= tree_carry;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      if (state == ST_RESOLVE) begin
        out_sum_q   <= s_q + c_q;
        out_beats_q <= cnt_q;
        out_valid_q <= 1'b1;
      end
      if (out_fire) begin
        out_valid_q <= 1'b0;
        s_q         <= '0;
        c_q         <= '0;
        cnt_q       <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;

endmodule
